pc_unit_stack: RTL and testbench

- Parametrised program-counter unit for the CPU datapath. Successor to the fixed 32-bit PC register.
- Adds configurable width, reset vector and increment step.
- Adds PC-relative branch, absolute load, pipeline stall, and a hardware return-address stack for call/return.
- Sits between the control unit and the memory address path. q drives instruction fetch.

---
 rtl/pc_unit_stack.sv | 130 +++++++++++++
 tb/tb_pc_unit_stack.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pc_unit_stack.sv
// Program counter with relative branch, absolute load, stall and a circular return-address stack.
// Optional sticky overflow/underflow flag stack_err when PC_STACK_ERR_EN is defined.
module pc_unit_stack #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      STEP        = 1,
    parameter int unsigned      STACK_DEPTH = 4
) (
    input  logic                               clock,
    input  logic                               clear,
    input  logic                               stall,
    input  logic                               inc_pc,
    input  logic                               enable,
    input  logic                               branch,
    input  logic                               call,
    input  logic                               ret,
    input  logic [WIDTH-1:0]                   d,
    input  logic [WIDTH-1:0]                   offset,
    output logic [WIDTH-1:0]                   q,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
    output logic                               stack_full,
    output logic                               stack_empty
`ifdef PC_STACK_ERR_EN
    ,
    output logic                               stack_err
`endif
);

    localparam int unsigned CW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned PW = $clog2(STACK_DEPTH);
    localparam logic [CW-1:0]    DepthC = CW'(STACK_DEPTH);
    localparam logic [PW-1:0]    PtrMax = PW'(STACK_DEPTH - 1);
    localparam logic [WIDTH-1:0] StepW  = WIDTH'(STEP);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic             full_q, empty_q;
    logic             push;
    logic             err_set;
    logic [WIDTH-1:0] pc_inc;
    logic [PW-1:0]    ptr_inc, ptr_dec;
    logic [WIDTH-1:0] mem [STACK_DEPTH];

    assign pc_inc  = pc_q + StepW;
    // ptr_q is the next slot to write; the top entry sits one below it.
    assign ptr_inc = (ptr_q == PtrMax) ? '0 : ptr_q + PW'(1);
    assign ptr_dec = (ptr_q == '0) ? PtrMax : ptr_q - PW'(1);

    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        push    = 1'b0;
        err_set = 1'b0;
        if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (count_q != '0) begin
                pc_d    = mem[ptr_dec];
                count_d = count_q - CW'(1);
                ptr_d   = ptr_dec;
            end else begin
                pc_d    = pc_inc;
                err_set = 1'b1;
            end
        end else if (call) begin
            push  = 1'b1;
            pc_d  = d;
            ptr_d = ptr_inc;
            // When full the write lands on the oldest entry and the count saturates.
            if (count_q != DepthC) begin
                count_d = count_q + CW'(1);
            end else begin
                err_set = 1'b1;
            end
        end else if (enable) begin
            pc_d = d;
        end else if (branch) begin
            pc_d = pc_inc + offset;
        end else if (inc_pc) begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            pc_q    <= RESET_VALUE;
            count_q <= '0;
            ptr_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            full_q  <= (count_d == DepthC);
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (!clear && push) begin
            mem[ptr_q] <= pc_inc;
        end
    end

`ifdef PC_STACK_ERR_EN
    logic err_q;

    always_ff @(posedge clock) begin
        if (clear) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign stack_err = err_q;
`else
    logic unused_err;
    assign unused_err = err_set;
`endif

    assign q           = pc_q;
    assign stack_count = count_q;
    assign stack_full  = full_q;
    assign stack_empty = empty_q;

endmodule

// File: tb/tb_pc_unit_stack.sv
// Scoreboard bench for pc_unit_stack: directed plan sequences then random traffic against a
// queue-based reference model.
module tb_pc_unit_stack;

    localparam int unsigned     W     = 32;
    localparam logic [W-1:0]    RV    = 32'h100;
    localparam int unsigned     STEPV = 1;
    localparam int unsigned     DEPTH = 4;

    logic         clock = 1'b0;
    logic         clear = 1'b0, stall = 1'b0, inc_pc = 1'b0, enable = 1'b0;
    logic         branch = 1'b0, call = 1'b0, ret = 1'b0;
    logic [W-1:0] d = '0, offset = '0;
    logic [W-1:0] q;
    logic [2:0]   stack_count;
    logic         stack_full, stack_empty;
    logic         err_dut;

    pc_unit_stack #(
        .WIDTH       (W),
        .RESET_VALUE (RV),
        .STEP        (STEPV),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .stall       (stall),
        .inc_pc      (inc_pc),
        .enable      (enable),
        .branch      (branch),
        .call        (call),
        .ret         (ret),
        .d           (d),
        .offset      (offset),
        .q           (q),
        .stack_count (stack_count),
        .stack_full  (stack_full),
        .stack_empty (stack_empty)
`ifdef PC_STACK_ERR_EN
        ,
        .stack_err   (err_dut)
`endif
    );

`ifndef PC_STACK_ERR_EN
    assign err_dut = 1'b0;
`endif

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] pc;
        logic [2:0]   cnt;
        logic         full;
        logic         empty;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_stk[$];
    logic [W-1:0] m_pc = '0;
    logic         m_err = 1'b0;
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model result for the following edge goes to the scoreboard.
    task automatic step(input logic clr, input logic stl, input logic inc, input logic en,
                        input logic br, input logic cl, input logic rt,
                        input logic [W-1:0] dv, input logic [W-1:0] ov);
        exp_t e;
        @(negedge clock);
        clear = clr; stall = stl; inc_pc = inc; enable = en;
        branch = br; call = cl; ret = rt; d = dv; offset = ov;
        if (clr) begin
            m_pc = RV;
            m_stk.delete();
            m_err = 1'b0;
        end else if (stl) begin
            m_pc = m_pc;
        end else if (rt) begin
            if (m_stk.size() > 0) begin
                m_pc = m_stk.pop_back();
            end else begin
                m_pc = m_pc + STEPV;
                m_err = 1'b1;
            end
        end else if (cl) begin
            m_stk.push_back(m_pc + STEPV);
            if (m_stk.size() > DEPTH) begin
                void'(m_stk.pop_front());
                m_err = 1'b1;
            end
            m_pc = dv;
        end else if (en) begin
            m_pc = dv;
        end else if (br) begin
            m_pc = m_pc + STEPV + ov;
        end else if (inc) begin
            m_pc = m_pc + STEPV;
        end
        e.pc    = m_pc;
        e.cnt   = 3'(m_stk.size());
        e.full  = (m_stk.size() == DEPTH);
        e.empty = (m_stk.size() == 0);
        e.err   = m_err;
        sb.push_back(e);
    endtask

    task automatic idle_op(input logic [W-1:0] dv);
        step(0, 0, 0, 1, 0, 0, 0, dv, '0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("q", q, e.pc);
                check("stack_count", W'(stack_count), W'(e.cnt));
                check("stack_full", W'(stack_full), W'(e.full));
                check("stack_empty", W'(stack_empty), W'(e.empty));
`ifdef PC_STACK_ERR_EN
                check("stack_err", W'(err_dut), W'(e.err));
`endif
            end
        end
    end

    initial begin : driver
        // Reset then three increments: 0x100 -> 0x103.
        step(1, 0, 0, 0, 0, 0, 0, '0, '0);
        repeat (3) step(0, 0, 1, 0, 0, 0, 0, '0, '0);
        // Negative branch and wrap.
        idle_op(32'h10);
        step(0, 0, 0, 0, 1, 0, 0, '0, 32'hFFFF_FFF8);
        idle_op(32'hFFFF_FFFF);
        step(0, 0, 1, 0, 0, 0, 0, '0, '0);
        // Nested call/return.
        idle_op(32'h20);
        step(0, 0, 0, 0, 0, 1, 0, 32'h400, '0);
        step(0, 0, 0, 0, 0, 1, 0, 32'h500, '0);
        repeat (2) step(0, 0, 0, 0, 0, 0, 1, '0, '0);
        // Overflow by one, drain, then underflow.
        idle_op(32'h0);
        for (int i = 1; i <= 5; i++) step(0, 0, 0, 0, 0, 1, 0, W'(i) << 8, '0);
        repeat (5) step(0, 0, 0, 0, 0, 0, 1, '0, '0);
        // Stall dominates; then ret beats call.
        idle_op(32'h50);
        step(0, 1, 1, 0, 0, 1, 1, 32'h777, '0);
        step(0, 0, 0, 0, 0, 1, 0, 32'h60, '0);
        step(0, 0, 0, 0, 0, 1, 1, 32'h888, '0);
        // Clear beats a call with three entries stacked.
        repeat (3) step(0, 0, 0, 0, 0, 1, 0, 32'h1234, '0);
        step(1, 0, 0, 0, 0, 1, 0, 32'h999, '0);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic [W-1:0] ov;
            ov = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 64)) - W'(32) : W'($urandom);
            step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, W'($urandom), ov);
        end
        step(0, 0, 0, 0, 0, 0, 0, '0, '0);
        repeat (3) @(posedge clock);
        #2;
        check("scoreboard_drained", W'(sb.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
